hilo_unit: RTL and testbench
============================

# hilo_unit

Parametrised HI/LO special-register unit for the execute stage of the MIPS pipeline. It owns the HI/LO pair and drives writes from MTHI/MTLO, multiply, divide and multiply-accumulate (MADD/MSUB) operations. It sequences a multi-cycle external divider through a start/done handshake and raises a pipeline stall while any multi-cycle operation is in flight. Compared with the previous HI/LO register it generalises data width, adds accumulate modes, adds explicit divider sequencing with flush-abort, and writes on the rising edge.

## Interface

Parameters:
- `W`, 32: width of HI and LO, and of each operand.
- `ACC_EN`, 1: when 1, MADD/MSUB are implemented; when 0, those opcodes act as NOP.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous active-low reset.
- `flushE`  in  1  squash the E-stage op; aborts a pending divide.
- `op_valid`  in  1  `op` is valid this cycle.
- `op`  in  3  000 NOP, 001 MTHI, 010 MTLO, 011 MUL, 100 DIV, 101 MADD, 110 MSUB, 111 reserved (NOP).
- `op_signed`  in  1  signed multiply/divide.
- `src_a`  in  W  MTHI/MTLO source; divide dividend.
- `src_b`  in  W  divide divisor.
- `mul_prod`  in  2W  combinational product from the external multiplier, with signedness already applied.
- `div_start`  out  1  one-cycle request to the divider.
- `div_signed`  out  1  qualifies `div_start`.
- `div_abort`  out  1  one-cycle cancel to the divider.
- `div_done`  in  1  one-cycle pulse; `div_result` is valid in that cycle.
- `div_result`  in  2W  {remainder, quotient}.
- `stall`  out  1  holds the F/D/E stages.
- `hi_out`, `lo_out`  out  W  committed HI/LO registers.

## Operation

- The FSM has three states: IDLE, DIV_WAIT and ACC. A new op is accepted only in IDLE, when `op_valid & ~flushE`.
- IDLE, MTHI: HI <= `src_a`. LO is unchanged.
- IDLE, MTLO: LO <= `src_a`. HI is unchanged.
- IDLE, MUL: {HI,LO} <= `mul_prod`.
- IDLE, DIV:
  - `div_start`=1 combinationally. `div_signed`=`op_signed`.
  - `stall`=1.
  - Next state is DIV_WAIT.
- DIV_WAIT:
  - `stall`=~`div_done`.
  - On `div_done`: HI <= `div_result[2W-1:W]`, LO <= `div_result[W-1:0]`, then go to IDLE.
  - The held DIV op is never restarted while waiting.
- DIV_WAIT with `flushE`:
  - `div_abort`=1 and the state goes to IDLE. No write occurs.
  - If `div_done` arrives in the same cycle, flush wins and the result is dropped.
  - Any `div_done` seen later in IDLE is ignored.
- IDLE, MADD/MSUB (ACC_EN=1):
  - `stall`=1. `mul_prod` is latched into the accumulate register `acc_p`.
  - Next state is ACC.
- ACC:
  - `stall`=0.
  - MADD: {HI,LO} <= {HI,LO} + `acc_p`. MSUB: {HI,LO} <= {HI,LO} - `acc_p`.
  - Arithmetic is modulo 2^(2W), with no overflow detection.
  - Next state is IDLE.
- ACC with `flushE`: no write; go to IDLE.
- MADD/MSUB with ACC_EN=0 behave as NOP. The FSM never enters ACC.
- Reset values: `hi_out`=0, `lo_out`=0, `acc_p`=0, state=IDLE. `div_start`, `div_abort` and `stall` are all 0.
- Reset asserted mid-divide returns the FSM to IDLE with no abort pulse; the divider shares the same reset.

## Timing

- MTHI, MTLO and MUL: the result is visible on `hi_out`/`lo_out` after the first rising edge. `stall` stays 0.
- MADD/MSUB:
  - `stall` is high for exactly 1 cycle.
  - The result is visible after the second edge.
  - An MFHI in the next instruction needs E-stage forwarding, which is provided outside this block.
- DIV:
  - `div_start` is high only in the acceptance cycle.
  - `stall` is high from acceptance through the cycle before `div_done`.
  - The result is visible on the edge that samples `div_done`.
  - Latency is 1 + the divider latency.
- `stall` and `div_start` are combinational from `op`, `op_valid` and `flushE` in IDLE. `flushE` must be glitch-free before the edge.
- `div_abort` is combinational from state and `flushE`.

## Structure

- Shared `defines.vh` / package holds:
  - the `HILO_OP_*` 3-bit opcode constants;
  - the FSM state encodings `HILO_IDLE`, `HILO_DIV_WAIT` and `HILO_ACC`.
- Sub-module `hilo_acc` is a 2W add/sub datapath with inputs {hi,lo}, `acc_p` and `sub`, producing a 2W output. It is instantiated only under `generate if (ACC_EN)`.
- The decoder must map ALU control codes to `op`. No ALU-control decoding happens inside this block.

## Test plan

- Reset then MTHI `src_a`=0xDEADBEEF followed by MTLO 0x12345678 -> `hi_out`=0xDEADBEEF and `lo_out`=0x12345678. `stall` is never asserted.
- MUL with `mul_prod`=0xFFFFFFFE_00000001 -> next edge gives HI=0xFFFFFFFE and LO=0x00000001.
- DIV with a 5-cycle divider and `div_result`={0x1,0x3} -> `div_start` pulses once and `stall` stays high for 5 cycles. Then HI=1 and LO=3, and `stall` drops in the `div_done` cycle.
- DIV with `flushE` asserted in the 3rd wait cycle -> `div_abort` pulses. HI/LO are unchanged, and a later `div_done` is ignored. Also drive `flushE` and `div_done` in the same cycle -> no write.
- HI/LO={0,5} then MADD with `mul_prod`=0x0000_0000_FFFF_FFFF -> after 2 edges HI=1 and LO=4. Repeat with MSUB from {0,0} and `mul_prod`=1 -> HI/LO={0xFFFFFFFF,0xFFFFFFFF}.
- With ACC_EN=0, MADD -> no stall and HI/LO are unchanged. Asserting `resetn`=0 in DIV_WAIT -> immediate IDLE with HI/LO=0.

Source files
------------

// File: rtl/hilo_unit_pkg.sv
// ----------------------------------------------------------------------------
// hilo_unit_pkg : opcodes, FSM states and helpers for the HI/LO unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package hilo_unit_pkg;

  localparam logic [2:0] HILO_OP_NOP  = 3'b000;
  localparam logic [2:0] HILO_OP_MTHI = 3'b001;
  localparam logic [2:0] HILO_OP_MTLO = 3'b010;
  localparam logic [2:0] HILO_OP_MUL  = 3'b011;
  localparam logic [2:0] HILO_OP_DIV  = 3'b100;
  localparam logic [2:0] HILO_OP_MADD = 3'b101;
  localparam logic [2:0] HILO_OP_MSUB = 3'b110;

  typedef enum logic [1:0] {
    HILO_IDLE     = 2'd0,
    HILO_DIV_WAIT = 2'd1,
    HILO_ACC      = 2'd2
  } hilo_state_e;

  function automatic logic hilo_is_acc(input logic [2:0] op);
    return (op == HILO_OP_MADD) || (op == HILO_OP_MSUB);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hilo_unit_if.sv
// ----------------------------------------------------------------------------
// hilo_unit_if : pipeline/multiplier/divider signals of the HI/LO unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface hilo_unit_if #(
  parameter int W = 32
);

  logic           flushE;
  logic           op_valid;
  logic [2:0]     op;
  logic           op_signed;
  logic [W-1:0]   src_a;
  logic [W-1:0]   src_b;
  logic [2*W-1:0] mul_prod;
  logic           div_start;
  logic           div_signed;
  logic           div_abort;
  logic           div_done;
  logic [2*W-1:0] div_result;
  logic           stall;
  logic [W-1:0]   hi_out;
  logic [W-1:0]   lo_out;

  modport master (
    output flushE, op_valid, op, op_signed, src_a, src_b, mul_prod,
           div_done, div_result,
    input  div_start, div_signed, div_abort, stall, hi_out, lo_out
  );

  modport slave (
    input  flushE, op_valid, op, op_signed, src_a, src_b, mul_prod,
           div_done, div_result,
    output div_start, div_signed, div_abort, stall, hi_out, lo_out
  );

endinterface

`default_nettype wire

// File: rtl/hilo_unit_acc.sv
// ----------------------------------------------------------------------------
// hilo_acc : 2W add/sub datapath for MADD/MSUB, wraps modulo 2^(2W)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hilo_acc #(
  parameter int W = 32
) (
  input  logic [2*W-1:0] hilo_i,
  input  logic [2*W-1:0] acc_p_i,
  input  logic           sub_i,
  output logic [2*W-1:0] res_o
);

  assign res_o = sub_i ? (hilo_i - acc_p_i) : (hilo_i + acc_p_i);

endmodule

`default_nettype wire

// File: rtl/hilo_unit.sv
// ----------------------------------------------------------------------------
// hilo_unit : HI/LO register pair with MUL/DIV/MADD/MSUB write sequencing
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int W      = 32,
  parameter bit ACC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  hilo_unit_if.slave  bus
);

  hilo_state_e    state_q;
  logic [W-1:0]   hi_q;
  logic [W-1:0]   lo_q;
  logic [2*W-1:0] acc_sum;
  logic           accept;
  logic           acc_op;
  logic           stall_w;

  assign accept = (state_q == HILO_IDLE) && bus.op_valid && !bus.flushE;
  assign acc_op = ACC_EN && hilo_is_acc(bus.op);

  assign bus.div_start  = accept && (bus.op == HILO_OP_DIV);
  assign bus.div_signed = bus.op_signed;
  assign bus.div_abort  = (state_q == HILO_DIV_WAIT) && bus.flushE;
  assign bus.stall      = stall_w;
  assign bus.hi_out     = hi_q;
  assign bus.lo_out     = lo_q;

  always_comb begin
    stall_w = 1'b0;
    case (state_q)
      HILO_IDLE:     stall_w = accept && ((bus.op == HILO_OP_DIV) || acc_op);
      HILO_DIV_WAIT: stall_w = !bus.div_done;
      default:       stall_w = 1'b0;
    endcase
  end

  // Product is captured at acceptance so the add/sub runs off a register
  // rather than chaining the multiplier into the 2W adder.
  generate
    if (ACC_EN) begin : g_acc
      logic [2*W-1:0] acc_p_q;
      logic           sub_q;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          acc_p_q <= '0;
          sub_q   <= 1'b0;
        end else if (accept && acc_op) begin
          acc_p_q <= bus.mul_prod;
          sub_q   <= (bus.op == HILO_OP_MSUB);
        end
      end

      hilo_acc #(.W(W)) u_acc (
        .hilo_i  ({hi_q, lo_q}),
        .acc_p_i (acc_p_q),
        .sub_i   (sub_q),
        .res_o   (acc_sum)
      );
    end else begin : g_no_acc
      assign acc_sum = {hi_q, lo_q};
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= HILO_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        HILO_IDLE: begin
          if (accept) begin
            case (bus.op)
              HILO_OP_MTHI: hi_q <= bus.src_a;
              HILO_OP_MTLO: lo_q <= bus.src_a;
              HILO_OP_MUL:  {hi_q, lo_q} <= bus.mul_prod;
              HILO_OP_DIV:  state_q <= HILO_DIV_WAIT;
              HILO_OP_MADD,
              HILO_OP_MSUB: if (ACC_EN) state_q <= HILO_ACC;
              default: ;
            endcase
          end
        end
        // A flush in the same cycle as div_done drops the result.
        HILO_DIV_WAIT: begin
          if (bus.flushE) begin
            state_q <= HILO_IDLE;
          end else if (bus.div_done) begin
            {hi_q, lo_q} <= bus.div_result;
            state_q      <= HILO_IDLE;
          end
        end
        HILO_ACC: begin
          if (!bus.flushE) {hi_q, lo_q} <= acc_sum;
          state_q <= HILO_IDLE;
        end
        default: state_q <= HILO_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hilo_unit.sv
// ----------------------------------------------------------------------------
// tb_hilo_unit : directed scoreboard bench for hilo_unit (ACC_EN=1 and 0)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hilo_unit;
  import hilo_unit_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  hilo_unit_if #(.W(32)) bus  ();
  hilo_unit_if #(.W(32)) bus0 ();

  hilo_unit #(.W(32), .ACC_EN(1'b1)) dut  (.clk(clk), .resetn(resetn), .bus(bus));
  hilo_unit #(.W(32), .ACC_EN(1'b0)) dut0 (.clk(clk), .resetn(resetn), .bus(bus0));

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];
  logic [63:0] m;
  logic [63:0] m0;
  logic [63:0] dexp;
  logic [31:0] da;
  logic [31:0] db;
  int          n_stall;
  int          n_start;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_hilo(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected <empty scoreboard>", tag, obs);
    end else begin
      e = sb_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic idle();
    bus.op_valid = 1'b0;
    bus.flushE   = 1'b0;
    bus.div_done = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [63:0] prod);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.mul_prod = prod;
  endtask

  // Single-cycle MTHI/MTLO write with its scoreboard entry.
  task automatic wr(input logic [2:0] op, input logic [31:0] a, input string tag);
    issue(op, a, 64'd0);
    #1 chk({tag, "_stall"}, 64'(bus.stall), 64'd0);
    if (op == HILO_OP_MTHI) m[63:32] = a;
    else                    m[31:0]  = a;
    sb_q.push_back(m);
    tick();
    idle();
    check_hilo(tag, {bus.hi_out, bus.lo_out});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus.flushE = 1'b0; bus.op_valid = 1'b0; bus.op = HILO_OP_NOP; bus.op_signed = 1'b0;
    bus.src_a = '0; bus.src_b = '0; bus.mul_prod = '0; bus.div_done = 1'b0; bus.div_result = '0;
    bus0.flushE = 1'b0; bus0.op_valid = 1'b0; bus0.op = HILO_OP_NOP; bus0.op_signed = 1'b0;
    bus0.src_a = '0; bus0.src_b = '0; bus0.mul_prod = '0; bus0.div_done = 1'b0; bus0.div_result = '0;
    m = '0;
    m0 = '0;
    repeat (2) tick();
    chk("rst_hilo",  {bus.hi_out, bus.lo_out}, 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_start", 64'(bus.div_start), 64'd0);
    chk("rst_abort", 64'(bus.div_abort), 64'd0);
    resetn = 1'b1;
    tick();

    wr(HILO_OP_MTHI, 32'hDEADBEEF, "mthi");
    wr(HILO_OP_MTLO, 32'h12345678, "mtlo");

    issue(HILO_OP_MUL, 32'd0, 64'hFFFFFFFE_00000001);
    m = 64'hFFFFFFFE_00000001;
    sb_q.push_back(m);
    #1 chk("mul_stall", 64'(bus.stall), 64'd0);
    tick();
    idle();
    check_hilo("mul", {bus.hi_out, bus.lo_out});

    // Divide 7/2 with a 5-cycle divider: expect {rem=1, quo=3}.
    da = 32'd7;
    db = 32'd2;
    dexp = {da % db, da / db};
    bus.src_b = db;
    bus.op_signed = 1'b0;
    issue(HILO_OP_DIV, da, 64'd0);
    sb_q.push_back(dexp);
    #1;
    chk("div_start_accept", 64'(bus.div_start), 64'd1);
    chk("div_stall_accept", 64'(bus.stall), 64'd1);
    chk("div_signed_u", 64'(bus.div_signed), 64'd0);
    n_stall = 1;
    n_start = 1;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bus.stall) n_stall++;
      if (bus.div_start) n_start++;
      chk("div_wait_hold", {bus.hi_out, bus.lo_out}, m);
      tick();
    end
    bus.div_done = 1'b1;
    bus.div_result = dexp;
    #1 chk("div_done_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.div_done = 1'b0;
    chk("div_stall_cycles", 64'(n_stall), 64'd5);
    chk("div_start_pulses", 64'(n_start), 64'd1);
    check_hilo("div", {bus.hi_out, bus.lo_out});
    m = dexp;

    // Flush in the 3rd wait cycle, then a stray div_done in IDLE.
    bus.op_signed = 1'b1;
    issue(HILO_OP_DIV, da, 64'd0);
    #1 chk("div_signed_s", 64'(bus.div_signed), 64'd1);
    tick();
    idle();
    tick();
    tick();
    bus.flushE = 1'b1;
    #1 chk("flush_abort", 64'(bus.div_abort), 64'd1);
    tick();
    bus.flushE = 1'b0;
    #1 chk("flush_abort_once", 64'(bus.div_abort), 64'd0);
    sb_q.push_back(m);
    check_hilo("flush_hold", {bus.hi_out, bus.lo_out});
    bus.div_done = 1'b1;
    bus.div_result = 64'hCAFEF00D_0BADBEEF;
    #1 chk("late_done_stall", 64'(bus.stall), 64'd0);
    tick();
    bus.div_done = 1'b0;
    sb_q.push_back(m);
    check_hilo("late_done_ignored", {bus.hi_out, bus.lo_out});

    // Flush and div_done in the same wait cycle: flush wins.
    issue(HILO_OP_DIV, da, 64'd0);
    tick();
    idle();
    bus.flushE = 1'b1;
    bus.div_done = 1'b1;
    bus.div_result = 64'h11111111_22222222;
    #1 chk("same_cycle_abort", 64'(bus.div_abort), 64'd1);
    tick();
    idle();
    sb_q.push_back(m);
    check_hilo("flush_done_same", {bus.hi_out, bus.lo_out});

    // MADD from {0,5} with 0xFFFFFFFF -> {1,4}.
    wr(HILO_OP_MTHI, 32'd0, "madd_pre_hi");
    wr(HILO_OP_MTLO, 32'd5, "madd_pre_lo");
    issue(HILO_OP_MADD, 32'd0, 64'h00000000_FFFFFFFF);
    #1 chk("madd_stall_accept", 64'(bus.stall), 64'd1);
    tick();
    idle();
    bus.mul_prod = 64'h0000ABCD_00001234;
    #1 chk("madd_stall_acc", 64'(bus.stall), 64'd0);
    sb_q.push_back(m);
    check_hilo("madd_edge1", {bus.hi_out, bus.lo_out});
    tick();
    m = m + 64'h00000000_FFFFFFFF;
    sb_q.push_back(m);
    check_hilo("madd_edge2", {bus.hi_out, bus.lo_out});
    chk("madd_result", m, 64'h00000001_00000004);

    // MSUB from {0,0} with 1 -> all ones.
    wr(HILO_OP_MTHI, 32'd0, "msub_pre_hi");
    wr(HILO_OP_MTLO, 32'd0, "msub_pre_lo");
    issue(HILO_OP_MSUB, 32'd0, 64'd1);
    tick();
    idle();
    tick();
    m = m - 64'd1;
    sb_q.push_back(m);
    check_hilo("msub", {bus.hi_out, bus.lo_out});

    // Flush while in ACC: no write.
    issue(HILO_OP_MADD, 32'd0, 64'd5);
    tick();
    idle();
    bus.flushE = 1'b1;
    tick();
    bus.flushE = 1'b0;
    sb_q.push_back(m);
    check_hilo("acc_flush", {bus.hi_out, bus.lo_out});

    // ACC_EN=0 instance: MADD is a NOP.
    bus0.op_valid = 1'b1;
    bus0.op = HILO_OP_MTLO;
    bus0.src_a = 32'd5;
    tick();
    bus0.op_valid = 1'b0;
    m0[31:0] = 32'd5;
    sb_q.push_back(m0);
    check_hilo("noacc_mtlo", {bus0.hi_out, bus0.lo_out});
    bus0.op_valid = 1'b1;
    bus0.op = HILO_OP_MADD;
    bus0.mul_prod = 64'd7;
    #1 chk("noacc_stall", 64'(bus0.stall), 64'd0);
    tick();
    bus0.op_valid = 1'b0;
    #1 chk("noacc_stall_after", 64'(bus0.stall), 64'd0);
    sb_q.push_back(m0);
    check_hilo("noacc_edge1", {bus0.hi_out, bus0.lo_out});
    tick();
    sb_q.push_back(m0);
    check_hilo("noacc_edge2", {bus0.hi_out, bus0.lo_out});

    // Reset asserted while waiting on the divider.
    issue(HILO_OP_DIV, da, 64'd0);
    tick();
    idle();
    tick();
    resetn = 1'b0;
    #1;
    m = '0;
    chk("rst_mid_div_hilo", {bus.hi_out, bus.lo_out}, m);
    chk("rst_mid_div_stall", 64'(bus.stall), 64'd0);
    chk("rst_mid_div_abort", 64'(bus.div_abort), 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    wr(HILO_OP_MTLO, 32'd9, "post_reset_mtlo");

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
